// File: rtl/integer_divider_if.sv
// integer_divider_if: start/done divide bus; master drives start/dividend/divisor, slave returns quotient/remainder/done/divide_by_zero
interface integer_divider_if #(parameter int N = 4);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         done;
  logic         divide_by_zero;
  modport master (output start, dividend, divisor, input quotient, remainder, done, divide_by_zero);
  modport slave (input start, dividend, divisor, output quotient, remainder, done, divide_by_zero);
endinterface

// File: rtl/integer_divider.sv
// integer_divider: N-bit unsigned restoring divider, one quotient bit per clock; ports clock, reset (async active-low), bus (slave: start/dividend/divisor in, quotient/remainder/done/divide_by_zero out)
module integer_divider #(
  parameter int N = 4
) (
  input logic clock,
  input logic reset,
  integer_divider_if.slave bus
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d, qsh_q, qsh_d;
  logic [N-1:0] quo_q, quo_d, rmd_q, rmd_d;
  logic done_q, done_d, dbz_q, dbz_d;
  logic [N:0] trial;
  logic ge;
  assign trial = {rem_q, dvd_q[N-1]};
  assign ge = trial >= {1'b0, dvs_q};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    rem_d = rem_q;
    qsh_d = qsh_q;
    quo_d = quo_q;
    rmd_d = rmd_q;
    dbz_d = dbz_q;
    done_d = state_q == DONE;
    case (state_q)
      IDLE: if (bus.start) begin
        dvd_d = bus.dividend;
        dvs_d = bus.divisor;
        rem_d = '0;
        qsh_d = '0;
        dbz_d = bus.divisor == '0;
        state_d = dbz_d ? DONE : BUSY;
        cnt_d = CW'(N);
        quo_d = dbz_d ? '1 : quo_q;
        rmd_d = dbz_d ? bus.dividend : rmd_q;
      end
      BUSY: begin
        dvd_d = dvd_q << 1;
        // a kept remainder is always below the divisor, so N bits suffice
        rem_d = ge ? N'(trial - {1'b0, dvs_q}) : trial[N-1:0];
        qsh_d = {qsh_q[N-2:0], ge};
        cnt_d = cnt_q - 1'b1;
        state_d = cnt_q == CW'(1) ? DONE : BUSY;
        quo_d = cnt_q == CW'(1) ? qsh_d : quo_q;
        rmd_d = cnt_q == CW'(1) ? rem_d : rmd_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      qsh_q <= '0;
      quo_q <= '0;
      rmd_q <= '0;
      done_q <= 1'b0;
      dbz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      rem_q <= rem_d;
      qsh_q <= qsh_d;
      quo_q <= quo_d;
      rmd_q <= rmd_d;
      done_q <= done_d;
      dbz_q <= dbz_d;
    end
  end
  assign bus.quotient = quo_q;
  assign bus.remainder = rmd_q;
  assign bus.done = done_q;
  assign bus.divide_by_zero = dbz_q;
endmodule

// File: tb/tb_integer_divider.sv
// tb_integer_divider: random and directed divisions scored against plain / and % arithmetic
module tb_integer_divider;
  localparam int N = 4;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
  integer_divider_if #(.N(N)) bus ();
  integer_divider #(.N(N)) dut (.clock(clock), .reset(reset), .bus(bus));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic run(input int a, input int b, input string tag);
    int lat;
    logic [31:0] eq, er;
    eq = b != 0 ? a / b : (1 << N) - 1;
    er = b != 0 ? a % b : a;
    @(negedge clock);
    bus.start = 1'b1;
    bus.dividend = N'(a);
    bus.divisor = N'(b);
    @(posedge clock);
    #1 bus.start = 1'b0;
    bus.dividend = N'($urandom);
    bus.divisor = N'($urandom);
    lat = 0;
    do begin
      @(posedge clock);
      #1 lat++;
    end while (!bus.done && lat < 40);
    check({tag, " latency"}, lat, b != 0 ? N + 1 : 1);
    check({tag, " quotient"}, bus.quotient, eq);
    check({tag, " remainder"}, bus.remainder, er);
    check({tag, " dbz"}, bus.divide_by_zero, b == 0);
    @(posedge clock);
    #1 check({tag, " done pulse"}, bus.done, 0);
    check({tag, " hold q"}, bus.quotient, eq);
    check({tag, " hold r"}, bus.remainder, er);
  endtask
  initial begin
    int nd;
    logic [31:0] cq, cr;
    bus.start = 1'b1;
    bus.dividend = 4'd5;
    bus.divisor = 4'd5;
    #20;
    check("rst done", bus.done, 0);
    check("rst q", bus.quotient, 0);
    check("rst r", bus.remainder, 0);
    check("rst dbz", bus.divide_by_zero, 0);
    @(negedge clock);
    reset = 1'b1;
    bus.start = 1'b0;
    run(13, 4, "13/4");
    run(15, 1, "15/1");
    run(7, 9, "7/9");
    run(8, 8, "8/8");
    run(0, 6, "0/6");
    run(11, 0, "11/0");
    run(12, 5, "12/5");
    @(negedge clock);
    bus.start = 1'b1;
    bus.dividend = 4'd13;
    bus.divisor = 4'd4;
    @(posedge clock);
    #1 bus.start = 1'b0;
    @(negedge clock);
    bus.start = 1'b1;
    bus.dividend = 4'd15;
    bus.divisor = 4'd3;
    @(posedge clock);
    #1 bus.start = 1'b0;
    bus.dividend = 4'd2;
    bus.divisor = 4'd1;
    nd = 0;
    cq = 0;
    cr = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clock);
      #1 if (bus.done) begin
        nd++;
        cq = bus.quotient;
        cr = bus.remainder;
      end
    end
    check("busy done count", nd, 1);
    check("busy q", cq, 3);
    check("busy r", cr, 1);
    @(negedge clock);
    bus.start = 1'b1;
    bus.dividend = 4'd14;
    bus.divisor = 4'd3;
    @(posedge clock);
    #1 bus.start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    #1 check("abort q", bus.quotient, 0);
    check("abort r", bus.remainder, 0);
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      #1 if (bus.done) nd++;
    end
    check("abort no done", nd, 0);
    @(negedge clock);
    reset = 1'b1;
    run(14, 3, "14/3 after abort");
    for (int i = 0; i < 30; i++) run(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), "random");
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) run(a, b, $sformatf("ex %0d/%0d", a, b));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
